// File: rtl/team_08_rect_engine_if.sv
// Config, pixel and hit bundle for the team_08 rectangle hit engine.
// master drives table writes and pixels; slave returns the registered hit results.
interface team_08_rect_engine_if #(
  parameter int unsigned NUM_RECTS = 8,
  parameter int unsigned X_W       = 9,
  parameter int unsigned Y_W       = 8
);
  localparam int unsigned ID_W = $clog2(NUM_RECTS);

  logic                 cfg_we;
  logic [ID_W-1:0]      cfg_idx;
  logic [X_W-1:0]       cfg_x0;
  logic [X_W-1:0]       cfg_x1;
  logic [Y_W-1:0]       cfg_y0;
  logic [Y_W-1:0]       cfg_y1;
  logic                 cfg_en;
  logic                 frame_start;
  logic                 pix_valid;
  logic [X_W-1:0]       x;
  logic [Y_W-1:0]       y;
  logic                 hit_valid;
  logic [NUM_RECTS-1:0] hit_mask;
  logic                 hit_any;
  logic [ID_W-1:0]      hit_id;

  modport master (
    output cfg_we, cfg_idx, cfg_x0, cfg_x1, cfg_y0, cfg_y1, cfg_en, frame_start,
    output pix_valid, x, y,
    input  hit_valid, hit_mask, hit_any, hit_id
  );

  modport slave (
    input  cfg_we, cfg_idx, cfg_x0, cfg_x1, cfg_y0, cfg_y1, cfg_en, frame_start,
    input  pix_valid, x, y,
    output hit_valid, hit_mask, hit_any, hit_id
  );
endinterface

// File: rtl/team_08_rect_engine.sv
// Double-buffered rectangle table with a 2-stage per-pixel hit test.
// Outputs a registered hit mask and the lowest-index winning slot.
module team_08_rect_engine #(
  parameter int unsigned NUM_RECTS = 8,
  parameter int unsigned X_W       = 9,
  parameter int unsigned Y_W       = 8
) (
  input  logic                  clk,
  input  logic                  nRst,
  team_08_rect_engine_if.slave  rect_io
);
  localparam int unsigned IdW = $clog2(NUM_RECTS);

  typedef struct packed {
    logic [X_W-1:0] x0;
    logic [X_W-1:0] x1;
    logic [Y_W-1:0] y0;
    logic [Y_W-1:0] y1;
    logic           en;
  } rect_t;

  rect_t shadow_q [NUM_RECTS];
  rect_t shadow_d [NUM_RECTS];
  rect_t active_q [NUM_RECTS];
  rect_t active_d [NUM_RECTS];
  rect_t cfg_rect;

  logic [NUM_RECTS-1:0] xin_d, xin_q;
  logic [NUM_RECTS-1:0] yin_d, yin_q;
  logic                 valid1_q;

  logic [NUM_RECTS-1:0] mask_d, hit_mask_q;
  logic [IdW-1:0]       id_d, hit_id_q;
  logic                 hit_valid_q, hit_any_q;

  assign cfg_rect = {rect_io.cfg_x0, rect_io.cfg_x1, rect_io.cfg_y0, rect_io.cfg_y1,
                     rect_io.cfg_en};

  // Commit copies the post-write shadow, so a coincident write reaches the new frame.
  always_comb begin
    shadow_d = shadow_q;
    if (rect_io.cfg_we && (32'(rect_io.cfg_idx) < NUM_RECTS)) begin
      shadow_d[rect_io.cfg_idx] = cfg_rect;
    end
    active_d = active_q;
    if (rect_io.frame_start) begin
      active_d = shadow_d;
    end
  end

  always_comb begin
    xin_d = '0;
    yin_d = '0;
    for (int i = 0; i < int'(NUM_RECTS); i++) begin
      xin_d[i] = active_q[i].en && (rect_io.x >= active_q[i].x0) &&
                 (rect_io.x <= active_q[i].x1);
      yin_d[i] = (rect_io.y >= active_q[i].y0) && (rect_io.y <= active_q[i].y1);
    end
  end

  always_comb begin
    mask_d = xin_q & yin_q & {NUM_RECTS{valid1_q}};
    id_d   = '0;
    for (int i = int'(NUM_RECTS) - 1; i >= 0; i--) begin
      if (mask_d[i]) begin
        id_d = IdW'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      shadow_q <= '{default: '0};
      active_q <= '{default: '0};
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      xin_q       <= '0;
      yin_q       <= '0;
      valid1_q    <= 1'b0;
      hit_valid_q <= 1'b0;
      hit_mask_q  <= '0;
      hit_any_q   <= 1'b0;
      hit_id_q    <= '0;
    end else begin
      xin_q       <= xin_d;
      yin_q       <= yin_d;
      valid1_q    <= rect_io.pix_valid;
      hit_valid_q <= valid1_q;
      hit_mask_q  <= mask_d;
      hit_any_q   <= |mask_d;
      hit_id_q    <= id_d;
    end
  end

  assign rect_io.hit_valid = hit_valid_q;
  assign rect_io.hit_mask  = hit_mask_q;
  assign rect_io.hit_any   = hit_any_q;
  assign rect_io.hit_id    = hit_id_q;
endmodule

// File: tb/tb_team_08_rect_engine.sv
// Bench for team_08_rect_engine: directed table/edge cases plus a random stream
// compared against a delayed behavioural model.
module tb_team_08_rect_engine;
  logic clk = 1'b0;
  logic nRst;
  always #5 clk = ~clk;

  team_08_rect_engine_if #(.NUM_RECTS(8), .X_W(9), .Y_W(8)) if8 ();
  team_08_rect_engine_if #(.NUM_RECTS(6), .X_W(9), .Y_W(8)) if6 ();

  team_08_rect_engine #(.NUM_RECTS(8), .X_W(9), .Y_W(8)) u_dut8 (
    .clk     (clk),
    .nRst    (nRst),
    .rect_io (if8)
  );

  team_08_rect_engine #(.NUM_RECTS(6), .X_W(9), .Y_W(8)) u_dut6 (
    .clk     (clk),
    .nRst    (nRst),
    .rect_io (if6)
  );

  int n_total = 0;
  int n_bad   = 0;

  typedef struct {
    int x0;
    int x1;
    int y0;
    int y1;
    bit en;
  } mrect_t;

  mrect_t      m_sh  [8];
  mrect_t      m_act [8];
  logic [12:0] exp_q [$];

  task automatic check_eq(input string tag, input logic [12:0] got, input logic [12:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) begin
      m_sh[i]  = '{0, 0, 0, 0, 1'b0};
      m_act[i] = '{0, 0, 0, 0, 1'b0};
    end
  endfunction

  function automatic void model_write(bit we, int idx, int x0, int x1, int y0, int y1,
                                      bit en, bit fs);
    if (we && idx < 8) m_sh[idx] = '{x0, x1, y0, y1, en};
    if (fs) m_act = m_sh;
  endfunction

  function automatic logic [7:0] model_mask(int px, int py);
    logic [7:0] m = '0;
    for (int i = 0; i < 8; i++) begin
      if (m_act[i].en && px >= m_act[i].x0 && px <= m_act[i].x1 &&
          py >= m_act[i].y0 && py <= m_act[i].y1) m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic [12:0] model_out(bit v, logic [7:0] m);
    logic [2:0] id = '0;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) begin
        id = 3'(i);
        break;
      end
    end
    return {v, m != 8'h00, id, m};
  endfunction

  function automatic logic [12:0] obs8();
    return {if8.hit_valid, if8.hit_any, if8.hit_id, if8.hit_mask};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if8.cfg_we = 1'b0; if8.cfg_idx = '0; if8.cfg_x0 = '0; if8.cfg_x1 = '0;
    if8.cfg_y0 = '0; if8.cfg_y1 = '0; if8.cfg_en = 1'b0; if8.frame_start = 1'b0;
    if8.pix_valid = 1'b0; if8.x = '0; if8.y = '0;
    if6.cfg_we = 1'b0; if6.cfg_idx = '0; if6.cfg_x0 = '0; if6.cfg_x1 = '0;
    if6.cfg_y0 = '0; if6.cfg_y1 = '0; if6.cfg_en = 1'b0; if6.frame_start = 1'b0;
    if6.pix_valid = 1'b0; if6.x = '0; if6.y = '0;
  endtask

  task automatic cfg(input int idx, input int x0, input int x1, input int y0, input int y1,
                     input bit en, input bit fs);
    if8.cfg_we = 1'b1; if8.cfg_idx = 3'(idx);
    if8.cfg_x0 = 9'(x0); if8.cfg_x1 = 9'(x1); if8.cfg_y0 = 8'(y0); if8.cfg_y1 = 8'(y1);
    if8.cfg_en = en; if8.frame_start = fs;
    model_write(1'b1, idx, x0, x1, y0, y1, en, fs);
    tick();
    if8.cfg_we = 1'b0; if8.frame_start = 1'b0;
  endtask

  task automatic frame();
    if8.frame_start = 1'b1;
    model_write(1'b0, 0, 0, 0, 0, 0, 1'b0, 1'b1);
    tick();
    if8.frame_start = 1'b0;
  endtask

  task automatic pix(input string tag, input int px, input int py, input logic [7:0] exp_mask,
                     input int exp_id);
    if8.pix_valid = 1'b1; if8.x = 9'(px); if8.y = 8'(py);
    tick();
    if8.pix_valid = 1'b0;
    check_eq({tag, "_lat1"}, 13'(if8.hit_valid), '0);
    tick();
    check_eq(tag, obs8(), {1'b1, exp_mask != 8'h00, 3'(exp_id), exp_mask});
  endtask

  task automatic cfg6(input int idx, input bit fs);
    if6.cfg_we = 1'b1; if6.cfg_idx = 3'(idx);
    if6.cfg_x0 = 9'd0; if6.cfg_x1 = 9'd511; if6.cfg_y0 = 8'd0; if6.cfg_y1 = 8'd255;
    if6.cfg_en = 1'b1; if6.frame_start = fs;
    tick();
    if6.cfg_we = 1'b0; if6.frame_start = 1'b0;
  endtask

  task automatic pix6(input string tag, input logic [6:0] exp);
    if6.pix_valid = 1'b1; if6.x = 9'd10; if6.y = 8'd10;
    tick();
    if6.pix_valid = 1'b0;
    tick();
    check_eq(tag, 13'({if6.hit_any, if6.hit_mask}), 13'(exp));
  endtask

  initial begin
    idle();
    model_reset();
    nRst = 1'b0;
    repeat (3) tick();
    check_eq("rst_out", obs8(), '0);
    nRst = 1'b1;
    tick();

    pix("empty_tbl", 123, 45, 8'h00, 0);
    cfg(3, 280, 300, 100, 140, 1'b1, 1'b0);
    pix("no_commit", 290, 120, 8'h00, 0);
    frame();
    pix("slot3", 290, 120, 8'h08, 3);
    pix("edge_lo", 280, 100, 8'h08, 3);
    pix("edge_hi", 300, 140, 8'h08, 3);
    pix("out_xl", 279, 100, 8'h00, 0);
    pix("out_xh", 301, 140, 8'h00, 0);
    pix("out_yl", 290, 99, 8'h00, 0);
    pix("out_yh", 290, 141, 8'h00, 0);

    cfg(1, 0, 511, 0, 100, 1'b1, 1'b0);
    cfg(5, 8, 24, 90, 210, 1'b1, 1'b0);
    frame();
    pix("overlap", 10, 95, 8'h22, 1);

    cfg(0, 50, 40, 0, 255, 1'b1, 1'b1);
    pix("empty_mid", 45, 10, 8'h02, 1);
    pix("empty_x0", 50, 10, 8'h02, 1);
    pix("empty_x1", 40, 10, 8'h02, 1);

    cfg(2, 100, 110, 200, 210, 1'b1, 1'b1);
    pix("fwd_write", 105, 205, 8'h04, 2);

    cfg(4, 7, 7, 150, 150, 1'b1, 1'b1);
    pix("degen_hit", 7, 150, 8'h10, 4);
    pix("degen_y", 7, 151, 8'h00, 0);
    pix("degen_x", 6, 150, 8'h00, 0);
    pix("degen_nb", 8, 150, 8'h20, 5);

    cfg6(6, 1'b0);
    cfg6(7, 1'b1);
    pix6("oob_idx", 7'h00);
    cfg6(5, 1'b1);
    pix6("idx_ok", {1'b1, 6'h20});

    for (int n = 0; n < 640; n++) begin
      bit v, we, fs, en;
      int px, py, idx, x0, x1, y0, y1;
      if (n == 320) begin
        idle();
        nRst = 1'b0;
        #1;
        check_eq("rst_async", obs8(), '0);
        model_reset();
        exp_q.delete();
        tick();
        nRst = 1'b1;
      end
      v   = ($urandom % 4) != 0;
      we  = ($urandom % 16) == 0;
      fs  = ($urandom % 24) == 0;
      en  = ($urandom % 4) != 0;
      px  = int'($urandom_range(511));
      py  = int'($urandom_range(255));
      idx = int'($urandom_range(7));
      x0  = int'($urandom_range(511));
      y0  = int'($urandom_range(255));
      x1  = x0 + int'($urandom_range(200)) - 10;
      y1  = y0 + int'($urandom_range(120)) - 10;
      if (x1 > 511) x1 = 511;
      if (x1 < 0) x1 = 0;
      if (y1 > 255) y1 = 255;
      if (y1 < 0) y1 = 0;

      if8.pix_valid = v; if8.x = 9'(px); if8.y = 8'(py);
      if8.cfg_we = we; if8.cfg_idx = 3'(idx); if8.cfg_en = en;
      if8.cfg_x0 = 9'(x0); if8.cfg_x1 = 9'(x1); if8.cfg_y0 = 8'(y0); if8.cfg_y1 = 8'(y1);
      if8.frame_start = fs;

      exp_q.push_back(model_out(v, v ? model_mask(px, py) : 8'h00));
      model_write(we, idx, x0, x1, y0, y1, en, fs);
      tick();
      if (exp_q.size() >= 2) check_eq("stream", obs8(), exp_q.pop_front());
    end

    idle();
    tick();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
